// File: rtl/mips32_alu_pkg.sv
// Shared constants for the MIPS32 adder datapath: default geometry and flag-vector bit positions.
package mips32_alu_pkg;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_STAGES    = 4;

    // Flag vector layout used by the adder's registered flags.
    localparam int FLAG_W = 4;
    localparam int ZERO   = 0;
    localparam int CARRY  = 1;
    localparam int OVF    = 2;
    localparam int NEG    = 3;

endpackage

// File: rtl/mips32_adder_slice.sv
// One slice of the pipelined adder: SLICE_W-bit add with carry in and carry out.
module mips32_adder_slice
    import mips32_alu_pkg::*;
#(
    parameter int SLICE_W = DEF_DATAWIDTH / DEF_STAGES
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    // Zero-extend by one bit so the carry-out falls out of the same addition.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/mips32_pipe_adder.sv
// Pipelined add/subtract unit. Each stage adds one DATAWIDTH/STAGES-bit slice and
// forwards the running sum, the carry and the operands still to be consumed.
// Stages hold a valid bit each and advance independently, so bubbles collapse
// and a stalled output back-pressures only as far as the pipeline is full.
// DATAWIDTH must be an integer multiple of STAGES.
module mips32_pipe_adder
    import mips32_alu_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int STAGES    = DEF_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] A_in,
    input  logic [DATAWIDTH-1:0] B_in,
    input  logic                 Cin,
    input  logic                 Sub,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] O_out,
    output logic                 Zero,
    output logic                 Carry,
    output logic                 Overflow,
    output logic                 Negative
);

    localparam int SLICE_W = DATAWIDTH / STAGES;
    localparam int MSB     = DATAWIDTH - 1;

    // Inputs seen by each stage: index 0 comes from the ports, index k from stage k-1's registers.
    logic [DATAWIDTH-1:0] a_stg [STAGES];
    logic [DATAWIDTH-1:0] b_stg [STAGES];
    logic [DATAWIDTH-1:0] s_stg [STAGES];
    logic [STAGES-1:0]    c_stg;

    logic [STAGES-1:0]    vld_p;   // per-stage occupancy
    logic [STAGES-1:0]    take;    // stage k can accept new content this cycle
    logic [STAGES-1:0]    ld;      // stage k loads new content this cycle

    logic [DATAWIDTH-1:0] b_eff;
    logic                 cin0;
    logic [DATAWIDTH-1:0] o_q;
    logic [FLAG_W-1:0]    flags_q;

    function automatic logic [FLAG_W-1:0] result_flags(
        input logic [DATAWIDTH-1:0] sum,
        input logic                 a_msb,
        input logic                 b_msb,
        input logic                 cout
    );
        logic [FLAG_W-1:0] f;
        f        = '0;
        f[ZERO]  = (sum == '0);
        f[CARRY] = cout;
        f[OVF]   = (a_msb == b_msb) && (sum[MSB] != a_msb);
        f[NEG]   = sum[MSB];
        return f;
    endfunction

    // Subtraction is A + ~B + 1; the external carry-in is ignored in that mode.
    assign b_eff = Sub ? ~B_in : B_in;
    assign cin0  = Sub ? 1'b1 : Cin;

    // A stage can take new content if it is empty or its own content moves on; walk from the output back.
    always_comb begin
        logic nxt;
        take = '0;
        nxt  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            take[k] = !vld_p[k] || nxt;
            nxt     = take[k];
        end
    end

    assign in_ready  = !rst && take[0];
    assign out_valid = vld_p[STAGES-1];

    // Stage loads: stage 0 on an input transfer, later stages when the upstream stage holds data.
    always_comb begin
        ld    = '0;
        ld[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = vld_p[k-1] && take[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE_W-1:0]   slice_sum;
        logic                 slice_cout;
        logic [DATAWIDTH-1:0] sum_nx;

        if (k == 0) begin : g_src
            assign a_stg[0] = A_in;
            assign b_stg[0] = b_eff;
            assign s_stg[0] = '0;
            assign c_stg[0] = cin0;
        end

        mips32_adder_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a    (a_stg[k][k*SLICE_W +: SLICE_W]),
            .b    (b_stg[k][k*SLICE_W +: SLICE_W]),
            .cin  (c_stg[k]),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        // Lower slices of the running sum are final and upper ones still zero, so OR merges this slice in.
        assign sum_nx = s_stg[k] | (DATAWIDTH'(slice_sum) << (k * SLICE_W));

        if (k < STAGES - 1) begin : g_mid
            logic [DATAWIDTH-1:0] a_q;
            logic [DATAWIDTH-1:0] b_q;
            logic [DATAWIDTH-1:0] s_q;
            logic                 c_q;
            logic                 vld_q;

            // Stage occupancy: refilled or drained whenever the stage can take new content.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (take[k]) begin
                    vld_q <= ld[k];
                end
            end

            // Stage data: operands, partial sum and carry captured together.
            always_ff @(posedge clk) begin
                if (ld[k]) begin
                    a_q <= a_stg[k];
                    b_q <= b_stg[k];
                    s_q <= sum_nx;
                    c_q <= slice_cout;
                end
            end

            assign a_stg[k+1] = a_q;
            assign b_stg[k+1] = b_q;
            assign s_stg[k+1] = s_q;
            assign c_stg[k+1] = c_q;
            assign vld_p[k]   = vld_q;
        end else begin : g_last
            logic vld_q;

            // Output stage: result and its flags are captured in the same edge; cleared on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q   <= 1'b0;
                    o_q     <= '0;
                    flags_q <= '0;
                end else begin
                    if (take[k]) begin
                        vld_q <= ld[k];
                    end
                    if (ld[k]) begin
                        o_q     <= sum_nx;
                        flags_q <= result_flags(sum_nx, a_stg[k][MSB], b_stg[k][MSB], slice_cout);
                    end
                end
            end

            assign vld_p[k] = vld_q;
        end
    end

    assign O_out    = o_q;
    assign Zero     = flags_q[ZERO];
    assign Carry    = flags_q[CARRY];
    assign Overflow = flags_q[OVF];
    assign Negative = flags_q[NEG];

endmodule

// File: tb/tb_mips32_pipe_adder.sv
// Bench for mips32_pipe_adder: default 32/4 instance plus 16/2 and 32/1 instances sharing stimulus.
module tb_mips32_pipe_adder;

    typedef struct packed {
        logic [31:0] o;
        logic [3:0]  f;   // {Zero, Carry, Overflow, Negative}
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        logic [31:0] o;
        logic [3:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic        cin, sub, in_valid, out_ready;

    logic        ready32, ov32, z32, c32, v32, n32;
    logic [31:0] o32;
    logic        ready16, ov16, z16, c16, v16, n16;
    logic [15:0] o16;
    logic        ready1, ov1, z1, c1, v1, n1;
    logic [31:0] o1;

    res_t q32[$];
    res_t q16[$];
    res_t q1[$];
    vec_t vecs [6];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips32_pipe_adder dut32 (
        .clk(clk), .rst(rst), .A_in(a_in), .B_in(b_in), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(ready32), .out_valid(ov32), .out_ready(out_ready),
        .O_out(o32), .Zero(z32), .Carry(c32), .Overflow(v32), .Negative(n32)
    );

    mips32_pipe_adder #(.DATAWIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .A_in(a_in[15:0]), .B_in(b_in[15:0]), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(ready16), .out_valid(ov16), .out_ready(out_ready),
        .O_out(o16), .Zero(z16), .Carry(c16), .Overflow(v16), .Negative(n16)
    );

    mips32_pipe_adder #(.DATAWIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .A_in(a_in), .B_in(b_in), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(ready1), .out_valid(ov1), .out_ready(out_ready),
        .O_out(o1), .Zero(z1), .Carry(c1), .Overflow(v1), .Negative(n1)
    );

    // Reference: whole-word arithmetic on a 64-bit value, flags taken from the definitions.
    function automatic res_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic c, input logic s);
        longint unsigned mask, aa, bb, full, o;
        logic z, cy, v, n, am, bm;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = {32'd0, (s ? ~b : b)} & mask;
        full = aa + bb + (s ? 64'd1 : {63'd0, c});
        o    = full & mask;
        cy   = ((full >> w) & 64'd1) != 64'd0;
        n    = ((o >> (w - 1)) & 64'd1) != 64'd0;
        am   = ((aa >> (w - 1)) & 64'd1) != 64'd0;
        bm   = ((bb >> (w - 1)) & 64'd1) != 64'd0;
        z    = (o == 64'd0);
        v    = (am == bm) && (n != am);
        r.o  = o[31:0];
        r.f  = {z, cy, v, n};
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_7FFF;
            5:       return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        a_in = rand_op();
        b_in = rand_op();
        cin  = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid32: got %b expected 0", ov32); end
        n_tests++; if (o32 !== 32'd0) begin n_fail++; $display("FAIL reset_o_out32: got %h expected 0", o32); end
        n_tests++; if ({z32, c32, v32, n32} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags32: got %b expected 0000", {z32, c32, v32, n32}); end
        n_tests++; if (ready32 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready32: got %b expected 0", ready32); end
        n_tests++; if ({ov16, ov1, ready16, ready1} !== 4'b0000) begin n_fail++; $display("FAIL reset_small: got %b expected 0000", {ov16, ov1, ready16, ready1}); end
        rst = 1'b0;
        #1;
        n_tests++; if ({ready32, ready16, ready1} !== 3'b111) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 111", {ready32, ready16, ready1}); end
    endtask

    task automatic test_directed();
        int  lat;
        logic got;
        vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0011};
        vecs[1] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 4'b1100};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0001};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b1100};
        vecs[4] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 4'b0100};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0110};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_in = vecs[i].a; b_in = vecs[i].b; cin = vecs[i].c; sub = vecs[i].s;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_tests++; if (ready32 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, ready32); end
            lat = 0; got = 1'b0;
            while (lat < 20 && !got) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (ov32 === 1'b1) got = 1'b1;
            end
            n_tests++; if (!got || lat != 4) begin n_fail++; $display("FAIL dir%0d_latency: got %0d cycles expected 4", i, lat); end
            n_tests++; if (o32 !== vecs[i].o) begin n_fail++; $display("FAIL dir%0d_o_out: got %h expected %h", i, o32, vecs[i].o); end
            n_tests++; if ({z32, c32, v32, n32} !== vecs[i].f) begin n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", i, {z32, c32, v32, n32}, vecs[i].f); end
        end
    endtask

    task automatic test_back_to_back();
        int   issued = 0, got = 0, first = -1, last = -1;
        res_t exp;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (issued < 16) begin rand_inputs(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (ov32 === 1'b1) begin
                n_tests++;
                if (q32.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_out: got out_valid=1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp = q32.pop_front();
                    if ({o32, z32, c32, v32, n32} !== exp) begin
                        n_fail++; $display("FAIL b2b_result: got %h/%b expected %h/%b", o32, {z32, c32, v32, n32}, exp.o, exp.f);
                    end
                    got++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            if (in_valid) begin
                n_tests++;
                if (ready32 !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_in_ready: got %b expected 1 at cycle %0d", ready32, cyc);
                end else begin
                    q32.push_back(ref_add(32, a_in, b_in, cin, sub));
                    issued++;
                end
            end
        end
        n_tests++; if (got != 16) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 16", got); end
        n_tests++; if (last - first != 15) begin n_fail++; $display("FAIL b2b_rate: got span %0d expected 15", last - first); end
        q32.delete();
    endtask

    task automatic test_backpressure();
        int   issued = 0, popped = 0, cyc = 0;
        logic prev_hold = 1'b0;
        logic exp_ready;
        res_t exp, held;
        held = '0;
        while (cyc < 300 && (issued < 24 || q32.size() > 0)) begin
            @(negedge clk);
            if (cyc >= 6 && cyc < 16) out_ready = 1'b0;
            else if (cyc < 30)        out_ready = 1'b1;
            else                      out_ready = ($urandom_range(0, 3) != 0);
            if (issued < 24 && (cyc < 30 || $urandom_range(0, 1) == 1)) begin rand_inputs(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            exp_ready = out_ready || (q32.size() < 4);
            n_tests++; if (ready32 !== exp_ready) begin n_fail++; $display("FAIL bp_in_ready: got %b expected %b at cycle %0d", ready32, exp_ready, cyc); end
            if (prev_hold) begin
                n_tests++;
                if (ov32 !== 1'b1 || {o32, z32, c32, v32, n32} !== held) begin
                    n_fail++; $display("FAIL bp_hold_stable: got %b %h/%b expected 1 %h/%b", ov32, o32, {z32, c32, v32, n32}, held.o, held.f);
                end
            end
            prev_hold = 1'b0;
            if (ov32 === 1'b1) begin
                n_tests++;
                if (q32.size() == 0) begin
                    n_fail++; $display("FAIL bp_unexpected_out: got out_valid=1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp = q32[0];
                    if ({o32, z32, c32, v32, n32} !== exp) begin
                        n_fail++; $display("FAIL bp_result: got %h/%b expected %h/%b", o32, {z32, c32, v32, n32}, exp.o, exp.f);
                    end
                    if (out_ready) begin void'(q32.pop_front()); popped++; end
                    else begin prev_hold = 1'b1; held = {o32, z32, c32, v32, n32}; end
                end
            end
            if (in_valid && ready32) begin
                q32.push_back(ref_add(32, a_in, b_in, cin, sub));
                issued++;
            end
            cyc++;
        end
        n_tests++; if (popped != 24 || q32.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d results (%0d pending) expected 24 (0)", popped, q32.size()); end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int spurious32 = 0, spurious16 = 0, spurious1 = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_inputs(); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({ov32, ov16, ov1} !== 3'b000) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 000", {ov32, ov16, ov1}); end
        n_tests++; if ({o32, z32, c32, v32, n32} !== 36'd0) begin n_fail++; $display("FAIL midrst_outputs32: got %h/%b expected 0", o32, {z32, c32, v32, n32}); end
        n_tests++; if ({o16, o1} !== 48'd0) begin n_fail++; $display("FAIL midrst_outputs_small: got %h %h expected 0", o16, o1); end
        n_tests++; if ({ready32, ready16, ready1} !== 3'b000) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 000", {ready32, ready16, ready1}); end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov32 !== 1'b0) spurious32++;
            if (ov16 !== 1'b0) spurious16++;
            if (ov1 !== 1'b0)  spurious1++;
        end
        n_tests++; if (spurious32 != 0) begin n_fail++; $display("FAIL midrst_stale32: got %0d stale cycles expected 0", spurious32); end
        n_tests++; if (spurious16 != 0) begin n_fail++; $display("FAIL midrst_stale16: got %0d stale cycles expected 0", spurious16); end
        n_tests++; if (spurious1 != 0)  begin n_fail++; $display("FAIL midrst_stale1: got %0d stale cycles expected 0", spurious1); end
    endtask

    task automatic test_small_stream();
        int   issued = 0, got16 = 0, got1 = 0;
        res_t exp;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (issued < 16) begin rand_inputs(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (ov16 === 1'b1) begin
                n_tests++;
                if (q16.size() == 0) begin
                    n_fail++; $display("FAIL s16_unexpected_out: got out_valid=1 expected 0");
                end else begin
                    exp = q16.pop_front(); got16++;
                    if ({o16, z16, c16, v16, n16} !== {exp.o[15:0], exp.f}) begin
                        n_fail++; $display("FAIL s16_result: got %h/%b expected %h/%b", o16, {z16, c16, v16, n16}, exp.o[15:0], exp.f);
                    end
                end
            end
            if (ov1 === 1'b1) begin
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++; $display("FAIL s1_unexpected_out: got out_valid=1 expected 0");
                end else begin
                    exp = q1.pop_front(); got1++;
                    if ({o1, z1, c1, v1, n1} !== exp) begin
                        n_fail++; $display("FAIL s1_result: got %h/%b expected %h/%b", o1, {z1, c1, v1, n1}, exp.o, exp.f);
                    end
                end
            end
            if (in_valid) begin
                n_tests++;
                if ({ready16, ready1} !== 2'b11) begin
                    n_fail++; $display("FAIL small_in_ready: got %b expected 11", {ready16, ready1});
                end else begin
                    q16.push_back(ref_add(16, a_in, b_in, cin, sub));
                    q1.push_back(ref_add(32, a_in, b_in, cin, sub));
                    issued++;
                end
            end
        end
        n_tests++; if (got16 != 16 || q16.size() != 0) begin n_fail++; $display("FAIL s16_count: got %0d expected 16", got16); end
        n_tests++; if (got1 != 16 || q1.size() != 0)   begin n_fail++; $display("FAIL s1_count: got %0d expected 16", got1); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_small_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
